// File: rtl/alu_seq_if.sv
// Request/response bundle between the datapath and the sequential ALU.
// Handshake: start is a request; it is accepted only on an edge where busy=0 and is otherwise dropped (not queued).
interface alu_seq_if #(parameter int WIDTH = 4);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] RES;
  logic [WIDTH-1:0] RES_HI;
  logic             C;
  logic             Z;
  logic             N;
  logic             V;
  logic             busy;
  logic             done;

  modport master (output start, op, A, B,
                  input  RES, RES_HI, C, Z, N, V, busy, done);
  modport slave  (input  start, op, A, B,
                  output RES, RES_HI, C, Z, N, V, busy, done);
endinterface

// File: rtl/alu_seq.sv
// Registered ten-op ALU with condition flags; MUL runs as a WIDTH-cycle shift-add sequence.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus,
  output logic     fsm_state
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_NAND = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     res_q, res_d, hi_q, hi_d;
  logic                 c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
  logic                 done_q, commit;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [WIDTH-1:0]     b_eff;
  logic                 cin;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       step_sum;
  logic [2*WIDTH-1:0]   step_prod;

  always_comb begin
    b_eff = (bus.op == OP_SUB) ? ~bus.B : bus.B;
    cin   = (bus.op == OP_SUB) ? 1'b1 : ((bus.op == OP_ADC) ? c_q : 1'b0);
    sum   = {1'b0, bus.A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    // Upper half accumulates A when the multiplier LSB is set, then the pair shifts right.
    step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    step_prod = {step_sum, prod_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    hi_d    = hi_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    a_d     = a_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            a_d     = bus.A;
            prod_d  = {{WIDTH{1'b0}}, bus.B};
            cnt_d   = '0;
            state_d = S_MUL;
          end else begin
            commit = 1'b1;
            if (bus.op <= OP_SHR) begin
              c_d  = 1'b0;
              v_d  = 1'b0;
              hi_d = '0;
              case (bus.op)
                OP_ADD, OP_ADC, OP_SUB: begin
                  res_d = sum[WIDTH-1:0];
                  c_d   = sum[WIDTH];
                  v_d   = (bus.A[WIDTH-1] == b_eff[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.A[WIDTH-1]);
                end
                OP_NAND: res_d = ~(bus.A & bus.B);
                OP_AND:  res_d = bus.A & bus.B;
                OP_OR:   res_d = bus.A | bus.B;
                OP_XOR:  res_d = bus.A ^ bus.B;
                OP_SHL: begin
                  res_d = {bus.A[WIDTH-2:0], 1'b0};
                  c_d   = bus.A[WIDTH-1];
                end
                default: begin
                  res_d = {1'b0, bus.A[WIDTH-1:1]};
                  c_d   = bus.A[0];
                end
              endcase
              z_d = (res_d == '0);
              n_d = res_d[WIDTH-1];
            end
          end
        end
      end
      default: begin
        prod_d = step_prod;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          commit  = 1'b1;
          state_d = S_IDLE;
          res_d   = step_prod[WIDTH-1:0];
          hi_d    = step_prod[2*WIDTH-1:WIDTH];
          c_d     = (step_prod[2*WIDTH-1:WIDTH] != '0);
          z_d     = (step_prod == '0);
          n_d     = step_prod[2*WIDTH-1];
          v_d     = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
      done_q  <= commit;
      a_q     <= a_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.RES    = res_q;
  assign bus.RES_HI = hi_q;
  assign bus.C      = c_q;
  assign bus.Z      = z_q;
  assign bus.N      = n_q;
  assign bus.V      = v_q;
  assign bus.busy   = (state_q == S_MUL);
  assign bus.done   = done_q;
  assign fsm_state  = (state_q == S_MUL);
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: WIDTH=4 and WIDTH=8 instances checked every cycle against a transaction-level model.
module tb_alu_seq;
  logic clk;
  logic rst;
  logic fsm4, fsm8;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;

  alu_seq_if #(.WIDTH(4)) bus4 ();
  alu_seq_if #(.WIDTH(8)) bus8 ();

  alu_seq #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(bus4), .fsm_state(fsm4));
  alu_seq #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(bus8), .fsm_state(fsm8));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural model: whole-operation arithmetic, MUL just waits WIDTH edges
  typedef struct {
    int     w;
    longint res, hi, prod;
    bit     c, z, n, v, done;
    int     rem;
  } mdl_t;
  mdl_t m[2];

  function automatic longint sext(input longint x, input int w);
    return (((x >> (w - 1)) & 1) != 0) ? x - (longint'(1) << w) : x;
  endfunction

  task automatic model_reset(input int i, input int w);
    m[i].w = w; m[i].res = 0; m[i].hi = 0; m[i].prod = 0;
    m[i].c = 0; m[i].z = 0; m[i].n = 0; m[i].v = 0; m[i].done = 0; m[i].rem = 0;
  endtask

  task automatic model_edge(input int i, input bit st, input int op, input longint a, input longint b);
    int w; longint mk, r, s; bit cin;
    w = m[i].w;
    mk = (longint'(1) << w) - 1;
    cin = m[i].c;
    r = 0; s = 0;
    m[i].done = 0;
    if (m[i].rem > 0) begin
      m[i].rem--;
      if (m[i].rem == 0) begin
        m[i].res = m[i].prod & mk;
        m[i].hi  = (m[i].prod >> w) & mk;
        m[i].c = (m[i].hi != 0);
        m[i].z = (m[i].prod == 0);
        m[i].n = ((m[i].hi >> (w - 1)) & 1) != 0;
        m[i].v = 0;
        m[i].done = 1;
      end
    end else if (st) begin
      if (op == 9) begin
        m[i].prod = a * b;
        m[i].rem = w;
      end else if (op >= 10) begin
        m[i].done = 1;
      end else begin
        case (op)
          0: begin r = a + b; s = sext(a, w) + sext(b, w); end
          1: begin r = a + b + longint'(cin); s = sext(a, w) + sext(b, w) + longint'(cin); end
          2: begin r = a + (~b & mk) + 1; s = sext(a, w) - sext(b, w); end
          3: r = ~(a & b) & mk;
          4: r = a & b;
          5: r = a | b;
          6: r = a ^ b;
          7: r = (a << 1) & mk;
          default: r = a >> 1;
        endcase
        m[i].c = 0; m[i].v = 0;
        if (op <= 2) begin
          m[i].c = ((r >> w) & 1) != 0;
          m[i].v = (s < -(longint'(1) << (w - 1))) || (s > (longint'(1) << (w - 1)) - 1);
        end else if (op == 7) m[i].c = ((a >> (w - 1)) & 1) != 0;
        else if (op == 8) m[i].c = (a & 1) != 0;
        m[i].res = r & mk;
        m[i].hi = 0;
        m[i].z = (m[i].res == 0);
        m[i].n = ((m[i].res >> (w - 1)) & 1) != 0;
        m[i].done = 1;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset(0, 4);
      model_reset(1, 8);
    end else begin
      model_edge(0, bus4.start, int'(bus4.op), longint'(bus4.A), longint'(bus4.B));
      model_edge(1, bus8.start, int'(bus8.op), longint'(bus8.A), longint'(bus8.B));
    end
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // compare process: every cycle, both instances
  always @(negedge clk) begin
    if (chk_en) begin
      check("m4_res",  32'(bus4.RES),    32'(m[0].res));
      check("m4_hi",   32'(bus4.RES_HI), 32'(m[0].hi));
      check("m4_flag", {28'd0, bus4.C, bus4.Z, bus4.N, bus4.V}, {28'd0, m[0].c, m[0].z, m[0].n, m[0].v});
      check("m4_busy", 32'(bus4.busy),   32'(m[0].rem > 0));
      check("m4_done", 32'(bus4.done),   32'(m[0].done));
      check("m8_res",  32'(bus8.RES),    32'(m[1].res));
      check("m8_hi",   32'(bus8.RES_HI), 32'(m[1].hi));
      check("m8_flag", {28'd0, bus8.C, bus8.Z, bus8.N, bus8.V}, {28'd0, m[1].c, m[1].z, m[1].n, m[1].v});
      check("m8_busy", 32'(bus8.busy),   32'(m[1].rem > 0));
      check("m8_done", 32'(bus8.done),   32'(m[1].done));
    end
  end

  // driver tasks: inputs change 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set4(input bit s, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    bus4.start = s; bus4.op = op; bus4.A = a; bus4.B = b;
  endtask

  task automatic set8(input bit s, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus8.start = s; bus8.op = op; bus8.A = a; bus8.B = b;
  endtask

  task automatic step4(input bit s, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    set4(s, op, a, b);
    tick();
    bus4.start = 1'b0;
  endtask

  task automatic step8(input bit s, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    set8(s, op, a, b);
    tick();
    bus8.start = 1'b0;
  endtask

  task automatic check_zero4(input string tag);
    check({tag, "_res"},  32'(bus4.RES),    32'd0);
    check({tag, "_hi"},   32'(bus4.RES_HI), 32'd0);
    check({tag, "_flag"}, {28'd0, bus4.C, bus4.Z, bus4.N, bus4.V}, 32'd0);
    check({tag, "_busy"}, 32'(bus4.busy),   32'd0);
    check({tag, "_done"}, 32'(bus4.done),   32'd0);
  endtask

  task automatic rand_op(output logic [3:0] op);
    op = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
  endtask

  initial begin
    logic [3:0] op_a, op_b;
    rst = 1'b0;
    set4(1'b0, 4'd0, 4'd0, 4'd0);
    set8(1'b0, 4'd0, 8'd0, 8'd0);

    // asynchronous reset with no clock edge
    #3 rst = 1'b1;
    #1 check_zero4("rst_async");
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check_zero4("rst_idle");

    // ADD/ADC chain
    step4(1'b1, 4'd0, 4'd7, 4'd9);
    check("add_res", 32'(bus4.RES), 32'd0);
    check("add_czn", {29'd0, bus4.C, bus4.Z, bus4.N}, 32'b110);
    check("add_v",    32'(bus4.V), 32'd0);
    check("add_done", 32'(bus4.done), 32'd1);
    step4(1'b1, 4'd1, 4'd3, 4'd4);
    check("adc_res", 32'(bus4.RES), 32'd8);
    check("adc_cnv", {29'd0, bus4.C, bus4.N, bus4.V}, 32'b011);
    check("adc_done", 32'(bus4.done), 32'd1);
    tick();
    check("done_drop", 32'(bus4.done), 32'd0);

    // SUB and logic
    step4(1'b1, 4'd2, 4'd5, 4'd7);
    check("sub_res", 32'(bus4.RES), 32'hE);
    check("sub_cnv", {29'd0, bus4.C, bus4.N, bus4.V}, 32'b010);
    step4(1'b1, 4'd3, 4'hC, 4'hA);
    check("nand_res", 32'(bus4.RES), 32'h7);
    check("nand_c",   32'(bus4.C), 32'd0);
    step4(1'b1, 4'd8, 4'h5, 4'h0);
    check("shr_res", 32'(bus4.RES), 32'h2);
    check("shr_c",   32'(bus4.C), 32'd1);

    // MUL 15x15 with an ignored start at k+2
    step4(1'b1, 4'd9, 4'hF, 4'hF);
    check("mul_busy_k", 32'(bus4.busy), 32'd1);
    step4(1'b0, 4'd0, 4'd0, 4'd0);
    step4(1'b1, 4'd0, 4'd1, 4'd1);
    step4(1'b0, 4'd0, 4'd0, 4'd0);
    check("mul_hold_res", 32'(bus4.RES), 32'h2);
    check("mul_hold_done", 32'(bus4.done), 32'd0);
    step4(1'b0, 4'd0, 4'd0, 4'd0);
    check("mul_res", 32'(bus4.RES), 32'h1);
    check("mul_hi",  32'(bus4.RES_HI), 32'hE);
    check("mul_czn", {29'd0, bus4.C, bus4.Z, bus4.N}, 32'b101);
    check("mul_busy_done", {30'd0, bus4.busy, bus4.done}, 32'b01);
    tick();
    check("mul_done_drop", 32'(bus4.done), 32'd0);

    // reset in the middle of a MUL
    step4(1'b1, 4'd9, 4'd3, 4'd5);
    step4(1'b0, 4'd0, 4'd0, 4'd0);
    step4(1'b0, 4'd0, 4'd0, 4'd0);
    #2 rst = 1'b1;
    #1 check_zero4("rst_mul");
    tick();
    rst = 1'b0;
    step4(1'b1, 4'd0, 4'd1, 4'd1);
    check("post_rst_add", 32'(bus4.RES), 32'd2);

    // WIDTH=8 MUL then NOP
    step8(1'b1, 4'd9, 8'hFF, 8'h02);
    repeat (7) step8(1'b0, 4'd0, 8'd0, 8'd0);
    check("mul8_early_done", 32'(bus8.done), 32'd0);
    step8(1'b0, 4'd0, 8'd0, 8'd0);
    check("mul8_prod", {16'd0, bus8.RES_HI, bus8.RES}, 32'h01FE);
    check("mul8_done", 32'(bus8.done), 32'd1);
    step8(1'b1, 4'd12, 8'h55, 8'hAA);
    check("nop8_done", 32'(bus8.done), 32'd1);
    check("nop8_prod", {16'd0, bus8.RES_HI, bus8.RES}, 32'h01FE);
    check("nop8_flag", {28'd0, bus8.C, bus8.Z, bus8.N, bus8.V}, 32'b1000);

    // randomized traffic on both instances
    for (int i = 0; i < 600; i++) begin
      rand_op(op_a);
      rand_op(op_b);
      set4(1'($urandom_range(0, 1)), op_a, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      set8(1'($urandom_range(0, 1)), op_b, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      tick();
    end
    set4(1'b0, 4'd0, 4'd0, 4'd0);
    set8(1'b0, 4'd0, 8'd0, 8'd0);
    repeat (10) tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 4-bit combinational add/NAND ALU. It executes one of ten operations on two WIDTH-bit operands, holds the result and condition flags in registers, and reports completion with a one-cycle done pulse. Most operations finish in one cycle. MUL is a multi-cycle shift-add sequence with a busy/done handshake. The block sits between the register file and the write-back path of the CPU datapath.

## Interface
- WIDTH, default 4: operand/result width, minimum 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op  in  4  opcode: 0 ADD, 1 ADC, 2 SUB, 3 NAND, 4 AND, 5 OR, 6 XOR, 7 SHL, 8 SHR, 9 MUL, 10-15 NOP.
- A  in  WIDTH  operand A; sampled with start.
- B  in  WIDTH  operand B; sampled with start.
- RES  out  WIDTH  result (low half for MUL).
- RES_HI  out  WIDTH  high half of MUL product; 0 after any non-MUL op.
- C, Z, N, V  out  1 each  carry, zero, negative, signed-overflow flags.
- busy  out  1  high while MUL is iterating.
- done  out  1  one-cycle pulse when a result/flag update has been committed.

## Operation
- Reset (asynchronous, any state, including mid-MUL): RES, RES_HI, C, Z, N, V, busy and done all go to 0; FSM goes to IDLE; any MUL in progress is discarded.
- FSM has two states: IDLE and MUL.
  - IDLE with start=1, op≠9: result and flags register at that edge; FSM stays in IDLE.
  - IDLE with start=1, op=9: A and B are latched into internal registers, the product accumulator and counter are cleared, and the FSM goes to MUL.
  - MUL: one shift-add iteration per cycle. After WIDTH iterations, the FSM returns to IDLE.
- start while busy=1 is ignored and is not queued.
- ADD: {C,RES} = A+B.
- ADC: {C,RES} = A+B+C, using the C value held before the edge.
- SUB: {C,RES} = A+~B+1. C=1 means no borrow (A≥B unsigned).
- V (ADD/ADC/SUB only): set when the operands' effective signs match and RES's sign differs. Otherwise V=0.
- NAND, AND, OR, XOR: bitwise. C=0, V=0.
- SHL: RES={A[WIDTH-2:0],0}, C=A[WIDTH-1], V=0. B is ignored.
- SHR (logical): RES={0,A[WIDTH-1:1]}, C=A[0], V=0. B is ignored.
- MUL (unsigned): {RES_HI,RES} = A*B. C=(RES_HI≠0), V=0.
- Z: 1 when RES=0. For MUL, Z is 1 when the whole 2·WIDTH-bit product is 0.
- N: the MSB of the committed result (RES_HI[WIDTH-1] for MUL).
- NOP (ops 10-15): RES, RES_HI and flags are unchanged; done still pulses.
- Outputs are updated only at commit. During MUL, RES, RES_HI and the flags hold their previous values.

## Timing
- Single-cycle ops: start is accepted at edge k. RES and flags are valid after edge k, and done=1 for the cycle following edge k.
- MUL: start is accepted at edge k, so busy=1 from edge k. RES, RES_HI and flags update at edge k+WIDTH, and at that same edge busy goes to 0 and done goes to 1 for one cycle.
- Back-to-back single-cycle ops: start can be held high every cycle, giving one result per cycle with done staying high.
- A new start can be accepted at the edge where MUL commits only if busy was 0 before that edge. Because busy is still 1 before that edge, the first accept after a MUL is at edge k+WIDTH+1.
- No combinational path from inputs to outputs.

## Test plan
- Reset values: assert rst mid-cycle with no clock edge -> all outputs 0 immediately. Release rst, apply no start -> all outputs remain 0.
- ADD/ADC chain (WIDTH=4): ADD 7+9 -> RES=0, C=1, Z=1, N=0, V=0, done for 1 cycle. Next cycle ADC 3+4 -> RES=8, C=0, N=1, V=1.
- SUB and logic: SUB 5−7 -> RES=0xE, C=0, N=1, V=0. NAND 0xC,0xA -> RES=0x7, C=0. SHR 0x5 -> RES=0x2, C=1.
- MUL 15×15 (WIDTH=4), start at edge k: busy from k. At edge k+4, RES=0x1, RES_HI=0xE, C=1, Z=0, N=1, and done pulses. A start pulse at k+2 is ignored.
- Reset during MUL at cycle k+2 -> busy=0 and all outputs 0. A subsequent ADD 1+1 -> RES=2 after one edge.
- WIDTH=8 instance: MUL 0xFF×0x02 -> {RES_HI,RES}=0x01FE after 8 cycles. NOP (op 12) -> done pulses and all outputs are unchanged.
